// File: rtl/secded_pkg.sv
// SECDED(16,11) decode engine shared definitions: FSM states, flag codes, default map.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: state_t (engine FSM states), FLG_* decode flag codes, default
// source/destination base addresses and word count.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] FLG_NONE = 2'b00;
  localparam logic [1:0] FLG_SGL  = 2'b01;
  localparam logic [1:0] FLG_DBL  = 2'b10;

  localparam int SRC_BASE_DEF  = 30;
  localparam int DST_BASE_DEF  = 0;
  localparam int NUM_WORDS_DEF = 15;

endpackage

// File: rtl/secded16_dec.sv
// Purely combinational SECDED(16,11) decoder: corrects single errors, flags doubles.
// Latency: 0 cycles (combinational).
// Backpressure: none; output follows input.
//
// Ports: word_i  16-bit received codeword {d11..d5,p8,d4..d2,p4,d1,p2,p1,p0}
//        data_o  11-bit extracted data {d11..d1}
//        flag_o  FLG_NONE / FLG_SGL / FLG_DBL
module secded16_dec
  import secded_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  always_comb begin
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (word_i[k]) syn = syn ^ 4'(k);
    end
    par   = ^word_i;
    fixed = word_i;
    // Odd overall parity means one flipped bit; syndrome 0 points at p0 itself.
    if (par) fixed[syn] = ~fixed[syn];
    data_o = {fixed[15:9], fixed[7:5], fixed[3]};
    if (par)               flag_o = FLG_SGL;
    else if (syn != 4'd0)  flag_o = FLG_DBL;
    else                   flag_o = FLG_NONE;
  end

endmodule

// File: rtl/secded_dec_engine.sv
// Memory-to-memory SECDED decode engine: reads NUM_WORDS codewords, writes decoded words.
// Latency: 5 cycles per word; done rises on the 76th edge counting the start-sampling edge (defaults).
// Backpressure: none; start is ignored while a run is in progress, memory is fixed-latency.
//
// Ports: clk, reset (sync, active high), start (sampled in IDLE/DONE), done (high in DONE),
//        mem_addr/mem_wr_en/mem_wdata to a byte memory, mem_rdata valid one cycle after mem_addr.
module secded_dec_engine
  import secded_pkg::*;
#(
  parameter int SRC_BASE  = SRC_BASE_DEF,
  parameter int DST_BASE  = DST_BASE_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int            IW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST  = IW'(NUM_WORDS - 1);
  localparam logic [7:0]    SRC_A = 8'(SRC_BASE);
  localparam logic [7:0]    DST_A = 8'(DST_BASE);

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic [7:0]    lo_q, hi_q;
  logic          done_q, wr_en_q;
  logic [7:0]    addr_q, wdata_q;

  logic [7:0]    off_cur, off_nxt;
  logic [15:0]   dec_in;
  logic [10:0]   dec_data;
  logic [1:0]    dec_flag;
  logic [15:0]   result;

  assign idx_d   = idx_q + IW'(1);
  assign off_cur = 8'({idx_q, 1'b0});
  assign off_nxt = 8'({idx_d, 1'b0});

  // In CAP_HI the high byte is still on mem_rdata; bypassing it lets the low
  // result byte be registered onto mem_wdata for WR_LO without an extra cycle.
  assign dec_in = (state_q == CAP_HI) ? {mem_rdata, lo_q} : {hi_q, lo_q};
  assign result = {dec_flag, 3'b000, dec_data};

  secded16_dec u_dec (
    .word_i (dec_in),
    .data_o (dec_data),
    .flag_o (dec_flag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RD_LO;
            idx_q   <= '0;
            done_q  <= 1'b0;
            addr_q  <= SRC_A;
          end
        end
        RD_LO: begin
          state_q <= RD_HI;
          addr_q  <= SRC_A + off_cur + 8'd1;
        end
        RD_HI: begin
          lo_q    <= mem_rdata;
          state_q <= CAP_HI;
        end
        CAP_HI: begin
          hi_q    <= mem_rdata;
          state_q <= WR_LO;
          addr_q  <= DST_A + off_cur;
          wr_en_q <= 1'b1;
          wdata_q <= result[7:0];
        end
        WR_LO: begin
          state_q <= WR_HI;
          addr_q  <= DST_A + off_cur + 8'd1;
          wdata_q <= result[15:8];
        end
        WR_HI: begin
          wr_en_q <= 1'b0;
          if (idx_q == LAST) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_d;
            state_q <= RD_LO;
            addr_q  <= SRC_A + off_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_secded_dec_engine.sv
// Self-checking bench for secded_dec_engine with a byte memory model and a decode scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_secded_dec_engine;
  import secded_pkg::*;

  localparam int SRC = 30;
  localparam int DST = 0;
  localparam int NW  = 15;

  logic       clk;
  logic       reset, start, done, mem_wr_en;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] src_w [NW];
  logic [15:0] exp_w [NW];
  logic [10:0] dat_w [NW];
  int          nfl   [NW];
  logic [15:0] e_w;

  int n_chk  = 0;
  int n_fail = 0;

  secded_dec_engine #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read byte memory.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Hamming(15,11) + overall parity encoder: data fills non-power-of-two positions.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int b = 1; b < 16; b = b * 2)
      for (int p = 1; p < 16; p++)
        if (p != b && (p & b) != 0) c[b] = c[b] ^ c[p];
    c[0] = ^c[15:1];
    return c;
  endfunction

  // Expected engine output for one received word.
  function automatic logic [15:0] model(input logic [15:0] w);
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  f;
    int s, ones, k;
    s = 0; ones = 0; k = 0; c = w; d = '0;
    for (int p = 0; p < 16; p++) begin
      if (w[p]) begin
        ones++;
        s = s ^ p;
      end
    end
    if (ones % 2 == 1) begin
      c[s] = ~c[s];
      f = FLG_SGL;
    end else if (s != 0) f = FLG_DBL;
    else f = FLG_NONE;
    for (int p = 1; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p];
        k++;
      end
    end
    return {f, 3'b000, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next expected {addr, data} in order.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 mem_addr, mem_wdata);
      end else begin
        e_w = exp_q.pop_front();
        chk("write_addr_data", {16'd0, mem_addr, mem_wdata}, {16'd0, e_w});
      end
    end
  end

  // Corrupt a fresh random codeword with one or two distinct bit flips.
  task automatic gen_word(input int i, input int flips);
    int p1, p2;
    dat_w[i] = 11'($urandom);
    nfl[i]   = flips;
    src_w[i] = encode(dat_w[i]);
    p1 = $urandom_range(0, 15);
    p2 = (p1 + $urandom_range(1, 15)) % 16;
    src_w[i][p1] = ~src_w[i][p1];
    if (flips == 2) src_w[i][p2] = ~src_w[i][p2];
  endtask

  task automatic prep();
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      mem[SRC + 2*i]     <= src_w[i][7:0];
      mem[SRC + 2*i + 1] <= src_w[i][15:8];
      mem[DST + 2*i]     <= 8'hAA;
      mem[DST + 2*i + 1] <= 8'hAA;
      exp_w[i] = model(src_w[i]);
      exp_q.push_back({8'(DST + 2*i), exp_w[i][7:0]});
      exp_q.push_back({8'(DST + 2*i + 1), exp_w[i][15:8]});
    end
    @(negedge clk);
  endtask

  // n counts edges from and including the one that samples start.
  task automatic run_timed(input bit hold, output int n);
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!hold) start = 1'b0;
    end while (done !== 1'b1 && n < 300);
    if (done !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: done=%b after %0d edges, required 1", done, n);
    end
  endtask

  task automatic check_dst();
    for (int i = 0; i < NW; i++)
      chk($sformatf("dst_word%0d", i), {16'd0, mem[DST + 2*i + 1], mem[DST + 2*i]}, {16'd0, exp_w[i]});
    chk("writes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    int n, k;
    for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
    chk("rst_addr", {24'd0, mem_addr}, 0);
    chk("rst_wdata", {24'd0, mem_wdata}, 0);

    // Pin the model to hand-computed values.
    chk("model_0000", {16'd0, model(16'h0000)}, 32'h0000);
    chk("model_0001", {16'd0, model(16'h0001)}, 32'h4000);
    chk("model_FFDF", {16'd0, model(16'hFFDF)}, 32'h47FF);
    chk("model_0003", {16'd0, model(16'h0003)}, 32'h8000);
    chk("encode_7FF", {16'd0, encode(11'h7FF)}, 32'hFFFF);
    reset = 1'b0;
    @(negedge clk);

    // Run 1: directed words then random corruptions.
    src_w[0] = 16'h0000; src_w[1] = 16'h0001; src_w[2] = 16'hFFDF; src_w[3] = 16'h0003;
    for (int i = 4; i < NW; i++) gen_word(i, (i % 2) + 1);
    prep();
    run_timed(1'b0, n);
    chk("latency_run1", n, 76);
    check_dst();
    chk("lit_0000", {16'd0, mem[DST+1], mem[DST+0]}, 32'h0000);
    chk("lit_0001", {16'd0, mem[DST+3], mem[DST+2]}, 32'h4000);
    chk("lit_FFDF", {16'd0, mem[DST+5], mem[DST+4]}, 32'h47FF);
    chk("lit_0003", {16'd0, mem[DST+7], mem[DST+6]}, 32'h8000);

    // Run 2: 15 random codewords, each with one or two flips.
    for (int i = 0; i < NW; i++) gen_word(i, $urandom_range(1, 2));
    prep();
    run_timed(1'b0, n);
    chk("latency_run2", n, 76);
    check_dst();
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("src_word%0d", i), {16'd0, mem[SRC + 2*i + 1], mem[SRC + 2*i]}, {16'd0, src_w[i]});
      if (nfl[i] == 1)
        chk($sformatf("single_fix%0d", i), {16'd0, mem[DST + 2*i + 1], mem[DST + 2*i]},
            {16'd0, 2'b01, 3'b000, dat_w[i]});
      else
        chk($sformatf("double_flag%0d", i), {31'd0, mem[DST + 2*i + 1][7]}, 1);
    end

    // Run 3: reset during word 7 WR_LO aborts the run.
    prep();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_wr_en === 1'b1 && mem_addr == 8'(DST + 14)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL abort_wait: word 7 WR_LO not seen within %0d cycles", k);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_wr_en", {31'd0, mem_wr_en}, 0);
    chk("abort_done", {31'd0, done}, 0);
    reset = 1'b0;
    chk("abort_writes_left", exp_q.size(), 15);
    chk("abort_dst14", {24'd0, mem[DST + 14]}, {24'd0, exp_w[7][7:0]});
    chk("abort_dst15", {24'd0, mem[DST + 15]}, 32'hAA);
    chk("abort_dst16", {24'd0, mem[DST + 16]}, 32'hAA);
    exp_q.delete();
    repeat (5) @(negedge clk);
    prep();
    run_timed(1'b0, n);
    chk("latency_rerun", n, 76);
    check_dst();

    // Run 4: start held high for the whole run.
    for (int i = 0; i < NW; i++) gen_word(i, $urandom_range(1, 2));
    prep();
    run_timed(1'b1, n);
    start = 1'b0;
    chk("latency_held", n, 76);
    repeat (5) @(negedge clk);
    chk("done_holds", {31'd0, done}, 1);
    check_dst();
    prep();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_clears_on_start", {31'd0, done}, 0);
    k = 0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_after_restart", {31'd0, done}, 1);
    check_dst();

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("final_rst_done", {31'd0, done}, 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
